// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: exhaustive stimulus/capture stage for a 3-input, 1-output
// combinational unit. Walks {a,b,c} through 000..111, holds each vector for
// SETTLE cycles and samples h_in on the last one into truth_table[idx].
// Optional feature macro: TT_SWEEP_COMPARE_EN adds a golden-table compare
// (expected input, mismatch output).
`timescale 1ns/1ps

module tt_sweep_capture #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       h_in,
  output logic [7:0] truth_table,
  output logic       busy,
  output logic       done
`ifdef TT_SWEEP_COMPARE_EN
  ,
  input  logic [7:0] expected,
  output logic       mismatch
`endif
);

  // A settle time of 0 behaves exactly like 1.
  localparam int unsigned SettleEff = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [CNT_W-1:0] Reload = CNT_W'(SettleEff - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tt_q, tt_d;

`ifdef TT_SWEEP_COMPARE_EN
  logic [7:0] exp_q, exp_d;
  logic       mm_q, mm_d;
`endif

  // Next-state logic: start acceptance, settle countdown, capture and advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
`ifdef TT_SWEEP_COMPARE_EN
    exp_d   = exp_q;
    mm_d    = mm_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          tt_d    = 8'h00;
          idx_d   = 3'd0;
          cnt_d   = Reload;
`ifdef TT_SWEEP_COMPARE_EN
          exp_d   = expected;
          mm_d    = 1'b0;
`endif
        end else if (state_q == StDone) begin
          state_d = StIdle;
          idx_d   = 3'd0;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          tt_d[idx_q] = h_in;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            cnt_d = Reload;
          end else begin
            // idx stays at 7 through DONE; it is cleared on the way out.
            state_d = StDone;
`ifdef TT_SWEEP_COMPARE_EN
            mm_d    = ({h_in, tt_q[6:0]} != exp_q);
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      tt_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
    end
  end

`ifdef TT_SWEEP_COMPARE_EN
  // Golden table latched at start; compare result held until next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= 8'h00;
      mm_q  <= 1'b0;
    end else begin
      exp_q <= exp_d;
      mm_q  <= mm_d;
    end
  end

  assign mismatch = mm_q;
`endif

  // Vector pins come straight from the index register.
  assign {a_out, b_out, c_out} = idx_q;
  assign truth_table           = tt_q;
  assign busy                  = (state_q == StRun);
  assign done                  = (state_q == StDone);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: three instances (SETTLE = 4, 1, 0)
// driven from a shared start/reset, each with its own behavioural UUT model.
`timescale 1ns/1ps

module tb_tt_sweep_capture;

  localparam int ModeXor = 0;
  localparam int ModeMaj = 1;
  localparam int ModeAnd = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  int   mode = ModeXor;

  logic       a4, b4, c4, h4, busy4, done4;
  logic       a1, b1, c1, h1, busy1, done1;
  logic       a0, b0, c0, h0, busy0, done0;
  logic [7:0] tt4, tt1, tt0;
`ifdef TT_SWEEP_COMPARE_EN
  logic [7:0] expected = 8'h00;
  logic       mm4, mm1, mm0;
  logic       mm4_at_done;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent sweep
  int done4_at, done1_at, done0_at, busy4_cnt, vec_err;

  always #5 clk = ~clk;

  function automatic logic h_fn(input int m, input logic a, input logic b, input logic c);
    case (m)
      ModeXor: return a ^ b ^ c;
      ModeMaj: return (a & b) | (a & c) | (b & c);
      default: return a & b & c;
    endcase
  endfunction

  assign h4 = h_fn(mode, a4, b4, c4);
  assign h1 = h_fn(mode, a1, b1, c1);
  assign h0 = h_fn(mode, a0, b0, c0);

  tt_sweep_capture #(.SETTLE(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_out(a4), .b_out(b4), .c_out(c4), .h_in(h4),
    .truth_table(tt4), .busy(busy4), .done(done4)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(expected), .mismatch(mm4)
`endif
  );

  tt_sweep_capture #(.SETTLE(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_out(a1), .b_out(b1), .c_out(c1), .h_in(h1),
    .truth_table(tt1), .busy(busy1), .done(done1)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(expected), .mismatch(mm1)
`endif
  );

  tt_sweep_capture #(.SETTLE(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_out(a0), .b_out(b0), .c_out(c0), .h_in(h0),
    .truth_table(tt0), .busy(busy0), .done(done0)
`ifdef TT_SWEEP_COMPARE_EN
    , .expected(expected), .mismatch(mm0)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then watch 40 cycles. Index 0 is the first RUN cycle.
  // extra_at >= 0 raises start again during that cycle index.
  task automatic sweep(input int m, input int extra_at);
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
    done4_at = -1; done1_at = -1; done0_at = -1;
    busy4_cnt = 0; vec_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy4) busy4_cnt++;
      if (i < 32 && {29'd0, a4, b4, c4} != 32'(i / 4)) vec_err++;
      if (done4 && done4_at < 0) begin
        done4_at = i;
`ifdef TT_SWEEP_COMPARE_EN
        mm4_at_done = mm4;
`endif
      end
      if (done1 && done1_at < 0) done1_at = i;
      if (done0 && done0_at < 0) done0_at = i;
      start = (i == extra_at);
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_vec", {29'd0, a4, b4, c4}, 32'd0);
    check_eq("rst_tt", {24'd0, tt4}, 32'd0);
    check_eq("rst_busy_done", {30'd0, busy4, done4}, 32'd0);
    reset_n = 1'b1;
    step();

    // XOR, SETTLE=4: 0x96, done 32 cycles after first RUN cycle
`ifdef TT_SWEEP_COMPARE_EN
    expected = 8'h96;
`endif
    sweep(ModeXor, -1);
    check_eq("xor_tt4", {24'd0, tt4}, 32'h96);
    check_eq("xor_done4_at", done4_at, 32'd32);
    check_eq("xor_busy4_cnt", busy4_cnt, 32'd32);
    check_eq("xor_vec_order", vec_err, 32'd0);
    check_eq("xor_tt1", {24'd0, tt1}, 32'h96);
    check_eq("xor_done1_at", done1_at, 32'd8);
`ifdef TT_SWEEP_COMPARE_EN
    check_eq("xor_mm_match", {31'd0, mm4_at_done}, 32'd0);
`endif

    // Majority: 0xE8, vectors held 4 cycles each, in order
    sweep(ModeMaj, -1);
    check_eq("maj_tt4", {24'd0, tt4}, 32'hE8);
    check_eq("maj_vec_order", vec_err, 32'd0);
    check_eq("maj_done4_at", done4_at, 32'd32);

    // AND: SETTLE=1 and SETTLE=0 identical, 8 cycles
    sweep(ModeAnd, -1);
    check_eq("and_tt1", {24'd0, tt1}, 32'h80);
    check_eq("and_tt0", {24'd0, tt0}, 32'h80);
    check_eq("and_done1_at", done1_at, 32'd8);
    check_eq("and_done0_at", done0_at, 32'd8);
    check_eq("and_tt4", {24'd0, tt4}, 32'h80);
    // Result held after DONE until next start
    check_eq("and_tt4_hold", {24'd0, tt4}, 32'h80);
    check_eq("and_idle_after", {30'd0, busy4, done4}, 32'd0);

    // Extra start during RUN cycle 10: ignored by SETTLE=4 instance
    sweep(ModeXor, 10);
    check_eq("extra_tt4", {24'd0, tt4}, 32'h96);
    check_eq("extra_done4_at", done4_at, 32'd32);
    check_eq("extra_busy4_cnt", busy4_cnt, 32'd32);

    // Async reset at RUN cycle 13
    mode = ModeXor;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    check_eq("pre_rst_tt4", {24'd0, tt4}, 32'h06);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_vec", {29'd0, a4, b4, c4}, 32'd0);
    check_eq("arst_tt", {24'd0, tt4}, 32'd0);
    check_eq("arst_busy_done", {30'd0, busy4, done4}, 32'd0);
    step();
    check_eq("arst_held_busy", {31'd0, busy4}, 32'd0);
    reset_n = 1'b1;
    step();

    // Full sweep after reset release
`ifdef TT_SWEEP_COMPARE_EN
    expected = 8'h97;
`endif
    sweep(ModeXor, -1);
    check_eq("post_rst_tt4", {24'd0, tt4}, 32'h96);
    check_eq("post_rst_done4_at", done4_at, 32'd32);
    check_eq("post_rst_busy4_cnt", busy4_cnt, 32'd32);
`ifdef TT_SWEEP_COMPARE_EN
    check_eq("mm_at_done", {31'd0, mm4_at_done}, 32'd1);
    check_eq("mm_held", {31'd0, mm4}, 32'd1);
    // Next accepted start clears it
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("mm_clear_on_start", {31'd0, mm4}, 32'd0);
    for (int i = 0; i < 40; i++) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
